// File: rtl/cpu_loader_pkg.sv
// Shared definitions for the byte-stream program loader: FSM states and frame field sizes.
package cpu_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_I_CNT,
        ST_I_DATA,
        ST_D_CNT,
        ST_D_DATA,
        ST_DRAIN,
        ST_RUN,
        ST_ERROR
    } state_t;

    localparam int COUNT_BYTES         = 2;
    localparam int IMEM_BYTES_PER_WORD = 4;
    localparam int DMEM_BYTES_PER_WORD = 8;

endpackage

// File: rtl/cpu_program_loader_byte_deserializer.sv
// Little-endian byte-to-word assembler; o_word is combinational and already includes the
// byte being accepted, so o_word_valid and o_word are usable in the same cycle.
module byte_deserializer #(
    parameter int WORD_BYTES = 8
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic                          i_clr,
    input  logic                          i_en,
    input  logic [7:0]                    i_byte,
    input  logic [$clog2(WORD_BYTES)-1:0] i_last_idx,
    output logic                          o_word_valid,
    output logic [WORD_BYTES*8-1:0]       o_word
);

    localparam int IDX_W = $clog2(WORD_BYTES);

    logic [IDX_W-1:0]        r_idx;
    logic [WORD_BYTES*8-1:0] r_buf;

    // Lower bytes were captured earlier in this word; bytes above the index are don't-care.
    always_comb begin
        o_word = r_buf;
        o_word[{r_idx, 3'b000} +: 8] = i_byte;
        o_word_valid = i_en && (r_idx == i_last_idx);
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            r_idx <= '0;
        end else if (i_en) begin
            r_idx <= o_word_valid ? '0 : r_idx + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_en) begin
            r_buf[{r_idx, 3'b000} +: 8] <= i_byte;
        end
    end

endmodule

// File: rtl/cpu_program_loader.sv
// Boot loader: parses an N/imem-words, M/dmem-words frame from a byte stream, writes both
// memories through their external ports, then enables the cpu.
module cpu_program_loader
    import cpu_loader_pkg::*;
#(
    parameter int IMEM_WORDS = 128,
    parameter int DMEM_WORDS = 128
) (
    input  logic        clk,
    input  logic        arst_n,
    input  logic        start,
    input  logic        abort,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [63:0] addr_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    output logic [31:0] wdata_ext,
    output logic [63:0] addr_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    output logic [63:0] wdata_ext_2,
    output logic        cpu_enable,
    output logic        busy,
    output logic        error
);

    state_t      r_state;
    state_t      w_next;
    logic        r_cnt_idx;
    logic [7:0]  r_cnt_lo;
    logic [15:0] r_count;
    logic [15:0] r_word_idx;

    logic        r_wen_ext;
    logic [63:0] r_addr_ext;
    logic [31:0] r_wdata_ext;
    logic        r_wen_ext_2;
    logic [63:0] r_addr_ext_2;
    logic [63:0] r_wdata_ext_2;

    logic        w_hs;
    logic        w_cnt_phase;
    logic        w_data_phase;
    logic        w_cnt_done;
    logic [15:0] w_count_val;
    logic        w_last_word;
    logic        w_des_en;
    logic        w_word_valid;
    logic [63:0] w_word;
    logic [2:0]  w_last_idx;

    assign w_hs         = in_valid && in_ready;
    assign w_cnt_phase  = (r_state == ST_I_CNT) || (r_state == ST_D_CNT);
    assign w_data_phase = (r_state == ST_I_DATA) || (r_state == ST_D_DATA);
    assign w_count_val  = {in_data, r_cnt_lo};
    assign w_cnt_done   = w_hs && w_cnt_phase && (r_cnt_idx == 1'(COUNT_BYTES - 1));
    assign w_last_word  = (r_word_idx == r_count - 16'd1);
    assign w_des_en     = w_hs && w_data_phase && !abort;
    assign w_last_idx   = (r_state == ST_I_DATA) ? 3'(IMEM_BYTES_PER_WORD - 1)
                                                 : 3'(DMEM_BYTES_PER_WORD - 1);

    // One 8-byte assembler serves both phases; imem words terminate after 4 bytes.
    byte_deserializer #(
        .WORD_BYTES(DMEM_BYTES_PER_WORD)
    ) u_deser (
        .i_clk       (clk),
        .i_rst_n     (arst_n),
        .i_clr       (abort),
        .i_en        (w_des_en),
        .i_byte      (in_data),
        .i_last_idx  (w_last_idx),
        .o_word_valid(w_word_valid),
        .o_word      (w_word)
    );

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        cpu_enable = 1'b0;
        error      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next = ST_I_CNT;
            end
            ST_I_CNT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_cnt_done) begin
                    if (w_count_val > 16'(IMEM_WORDS)) w_next = ST_ERROR;
                    else if (w_count_val == 16'd0)     w_next = ST_D_CNT;
                    else                               w_next = ST_I_DATA;
                end
            end
            ST_I_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_word_valid && w_last_word) w_next = ST_D_CNT;
            end
            ST_D_CNT: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_cnt_done) begin
                    if (w_count_val > 16'(DMEM_WORDS)) w_next = ST_ERROR;
                    else if (w_count_val == 16'd0)     w_next = ST_DRAIN;
                    else                               w_next = ST_D_DATA;
                end
            end
            ST_D_DATA: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (w_word_valid && w_last_word) w_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                busy   = 1'b1;
                w_next = ST_RUN;
            end
            ST_RUN: begin
                cpu_enable = 1'b1;
            end
            ST_ERROR: begin
                error = 1'b1;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
        if (abort) w_next = ST_IDLE;
    end

    always_ff @(posedge clk) begin
        if (!arst_n || abort) begin
            r_cnt_idx <= 1'b0;
            r_cnt_lo  <= '0;
            r_count   <= '0;
        end else if (w_hs && w_cnt_phase) begin
            if (w_cnt_done) begin
                r_cnt_idx <= 1'b0;
                r_count   <= w_count_val;
            end else begin
                r_cnt_idx <= r_cnt_idx + 1'b1;
                r_cnt_lo  <= in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n || abort || w_cnt_done) begin
            r_word_idx <= '0;
        end else if (w_word_valid) begin
            r_word_idx <= w_last_word ? 16'd0 : r_word_idx + 16'd1;
        end
    end

    // Write port stage: strobe, address and word land one cycle after the final byte.
    always_ff @(posedge clk) begin
        if (!arst_n || abort) begin
            r_wen_ext     <= 1'b0;
            r_addr_ext    <= '0;
            r_wdata_ext   <= '0;
            r_wen_ext_2   <= 1'b0;
            r_addr_ext_2  <= '0;
            r_wdata_ext_2 <= '0;
        end else begin
            r_wen_ext   <= 1'b0;
            r_wen_ext_2 <= 1'b0;
            if (w_word_valid) begin
                if (r_state == ST_I_DATA) begin
                    r_wen_ext   <= 1'b1;
                    r_addr_ext  <= {46'd0, r_word_idx, 2'b00};
                    r_wdata_ext <= w_word[31:0];
                end else begin
                    r_wen_ext_2   <= 1'b1;
                    r_addr_ext_2  <= {45'd0, r_word_idx, 3'b000};
                    r_wdata_ext_2 <= w_word;
                end
            end
        end
    end

    assign wen_ext     = r_wen_ext;
    assign addr_ext    = r_addr_ext;
    assign wdata_ext   = r_wdata_ext;
    assign wen_ext_2   = r_wen_ext_2;
    assign addr_ext_2  = r_addr_ext_2;
    assign wdata_ext_2 = r_wdata_ext_2;
    assign ren_ext     = 1'b0;
    assign ren_ext_2   = 1'b0;

endmodule

// File: tb/tb_cpu_program_loader.sv
// Bench for cpu_program_loader: table-driven frames, hand-written corner sequences and
// random frames scored against a frame-parsing reference model.
module tb_cpu_program_loader;

    localparam int IMEM_WORDS = 128;
    localparam int DMEM_WORDS = 128;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        start;
    logic        abort;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] addr_ext;
    logic        wen_ext;
    logic        ren_ext;
    logic [31:0] wdata_ext;
    logic [63:0] addr_ext_2;
    logic        wen_ext_2;
    logic        ren_ext_2;
    logic [63:0] wdata_ext_2;
    logic        cpu_enable;
    logic        busy;
    logic        error;

    cpu_program_loader #(
        .IMEM_WORDS(IMEM_WORDS),
        .DMEM_WORDS(DMEM_WORDS)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .start      (start),
        .abort      (abort),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .addr_ext   (addr_ext),
        .wen_ext    (wen_ext),
        .ren_ext    (ren_ext),
        .wdata_ext  (wdata_ext),
        .addr_ext_2 (addr_ext_2),
        .wen_ext_2  (wen_ext_2),
        .ren_ext_2  (ren_ext_2),
        .wdata_ext_2(wdata_ext_2),
        .cpu_enable (cpu_enable),
        .busy       (busy),
        .error      (error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] addr;
        logic [63:0] data;
        int          cyc;
    } wr_t;

    typedef struct {
        int n;
        int m;
        int vmode;
        bit exp_err;
        int exp_iw;
        int exp_dw;
    } vec_t;

    wr_t        obs_i[$];
    wr_t        obs_d[$];
    wr_t        exp_i[$];
    wr_t        exp_d[$];
    logic [7:0] frame[$];
    int         acc_cyc[0:2047];
    bit         exp_err;
    int         exp_consume;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;
    int         en_rise = -1;
    logic       en_prev = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (wen_ext)   obs_i.push_back('{addr_ext, 64'(wdata_ext), cyc});
        if (wen_ext_2) obs_d.push_back('{addr_ext_2, wdata_ext_2, cyc});
        checks++;
        if (wen_ext && wen_ext_2) begin
            errors++;
            $display("FAIL wen_exclusive: both strobes high at cycle %0d", cyc);
        end
        if (cpu_enable && !en_prev && en_rise < 0) en_rise = cyc;
        en_prev = cpu_enable;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=0x%0h expected=0x%0h", nm, act, exp);
        end
    endtask

    // Reference model: walk the frame by its field rules and list the writes it implies.
    task automatic model();
        int p;
        int n;
        int m;
        logic [63:0] w;
        exp_i.delete();
        exp_d.delete();
        exp_err = 1'b0;
        n = int'(frame[0]) + 256 * int'(frame[1]);
        p = 2;
        if (n > IMEM_WORDS) begin
            exp_err = 1'b1;
            exp_consume = p;
            return;
        end
        for (int i = 0; i < n; i++) begin
            w = '0;
            for (int k = 0; k < 4; k++) w = w | (64'(frame[p + k]) << (8 * k));
            exp_i.push_back('{64'(4 * i), w, p + 3});
            p += 4;
        end
        m = int'(frame[p]) + 256 * int'(frame[p + 1]);
        p += 2;
        if (m > DMEM_WORDS) begin
            exp_err = 1'b1;
            exp_consume = p;
            return;
        end
        for (int j = 0; j < m; j++) begin
            w = '0;
            for (int k = 0; k < 8; k++) w = w | (64'(frame[p + k]) << (8 * k));
            exp_d.push_back('{64'(8 * j), w, p + 7});
            p += 8;
        end
        exp_consume = p;
    endtask

    task automatic build_frame(input int n, input int m);
        frame.delete();
        frame.push_back(n[7:0]);
        frame.push_back(n[15:8]);
        if (n <= IMEM_WORDS) begin
            for (int i = 0; i < n * 4; i++) frame.push_back(8'($urandom));
            frame.push_back(m[7:0]);
            frame.push_back(m[15:8]);
            if (m <= DMEM_WORDS)
                for (int j = 0; j < m * 8; j++) frame.push_back(8'($urandom));
        end
    endtask

    // Called at a falling edge; returns at a falling edge with in_valid low.
    task automatic send(input int count, input int vmode);
        bit tog = 1'b1;
        bit hs;
        int waited;
        for (int idx = 0; idx < count; idx++) begin
            waited = 0;
            forever begin
                case (vmode)
                    0:       in_valid = 1'b1;
                    1:       in_valid = tog;
                    default: in_valid = ($urandom % 3) != 0;
                endcase
                tog = ~tog;
                in_data = in_valid ? frame[idx] : 8'h5a;
                hs = in_valid && in_ready;
                if (hs) acc_cyc[idx] = cyc;
                @(negedge clk);
                if (hs) break;
                waited++;
                if (waited > 200) begin
                    checks++;
                    errors++;
                    $display("FAIL send_timeout: byte %0d not accepted", idx);
                    in_valid = 1'b0;
                    return;
                end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic do_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic run_frame(input int vmode);
        int ni;
        int nd;
        obs_i.delete();
        obs_d.delete();
        en_rise = -1;
        model();
        pulse_start();
        send(exp_consume, vmode);
        repeat (4) @(negedge clk);
        chk("imem_write_count", 64'(obs_i.size()), 64'(exp_i.size()));
        chk("dmem_write_count", 64'(obs_d.size()), 64'(exp_d.size()));
        ni = (obs_i.size() < exp_i.size()) ? obs_i.size() : exp_i.size();
        nd = (obs_d.size() < exp_d.size()) ? obs_d.size() : exp_d.size();
        for (int i = 0; i < ni; i++) begin
            chk("imem_addr", obs_i[i].addr, exp_i[i].addr);
            chk("imem_data", obs_i[i].data, exp_i[i].data);
            chk("imem_latency", 64'(obs_i[i].cyc), 64'(acc_cyc[exp_i[i].cyc] + 1));
        end
        for (int j = 0; j < nd; j++) begin
            chk("dmem_addr", obs_d[j].addr, exp_d[j].addr);
            chk("dmem_data", obs_d[j].data, exp_d[j].data);
            chk("dmem_latency", 64'(obs_d[j].cyc), 64'(acc_cyc[exp_d[j].cyc] + 1));
        end
        chk("error_flag", 64'(error), 64'(exp_err));
        if (!exp_err) begin
            chk("enable_latency", 64'(en_rise), 64'(acc_cyc[exp_consume - 1] + 2));
            chk("run_enable", 64'(cpu_enable), 64'd1);
            chk("run_busy", 64'(busy), 64'd0);
        end else begin
            chk("error_no_enable", 64'(en_rise), 64'(-1));
            chk("error_in_ready", 64'(in_ready), 64'd0);
        end
        if (exp_i.size() > 0) chk("imem_addr_hold", addr_ext, exp_i[exp_i.size() - 1].addr);
    endtask

    vec_t tbl[8];

    initial begin
        tbl[0] = '{2,   1,   0, 1'b0, 2,   1};
        tbl[1] = '{0,   0,   0, 1'b0, 0,   0};
        tbl[2] = '{129, 0,   0, 1'b1, 0,   0};
        tbl[3] = '{1,   0,   1, 1'b0, 1,   0};
        tbl[4] = '{128, 128, 2, 1'b0, 128, 128};
        tbl[5] = '{3,   129, 2, 1'b1, 3,   0};
        tbl[6] = '{0,   3,   1, 1'b0, 0,   3};
        tbl[7] = '{5,   2,   2, 1'b0, 5,   2};

        arst_n   = 1'b0;
        start    = 1'b1;
        abort    = 1'b0;
        in_valid = 1'b1;
        in_data  = 8'hff;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_wen_ext", 64'(wen_ext), 64'd0);
        chk("rst_wen_ext_2", 64'(wen_ext_2), 64'd0);
        chk("rst_addr_ext", addr_ext, 64'd0);
        chk("rst_wdata_ext_2", wdata_ext_2, 64'd0);
        chk("rst_cpu_enable", 64'(cpu_enable), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_error", 64'(error), 64'd0);
        chk("rst_ren", 64'({ren_ext, ren_ext_2}), 64'd0);
        start    = 1'b0;
        in_valid = 1'b0;
        arst_n   = 1'b1;
        @(negedge clk);
        chk("idle_busy", 64'(busy), 64'd0);

        // Reference program image with fixed words.
        frame = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'ha0, 8'h00,
                  8'h01, 8'h00, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
        run_frame(0);
        if (obs_i.size() == 2 && obs_d.size() == 1) begin
            chk("plan_iw0", obs_i[0].data, 64'h00500093);
            chk("plan_iw1", obs_i[1].data, 64'h00a00113);
            chk("plan_ia1", obs_i[1].addr, 64'd4);
            chk("plan_dw0", obs_d[0].data, 64'h1122334455667788);
        end else begin
            chk("plan_write_shape", 64'({obs_i.size(), obs_d.size()}), 64'({32'd2, 32'd1}));
        end

        // start while running is ignored; abort stops the cpu.
        pulse_start();
        @(negedge clk);
        chk("run_start_ignored_enable", 64'(cpu_enable), 64'd1);
        chk("run_start_ignored_busy", 64'(busy), 64'd0);
        do_abort();
        chk("abort_run_enable", 64'(cpu_enable), 64'd0);

        foreach (tbl[t]) begin
            build_frame(tbl[t].n, tbl[t].m);
            run_frame(tbl[t].vmode);
            chk("tbl_imem_writes", 64'(obs_i.size()), 64'(tbl[t].exp_iw));
            chk("tbl_dmem_writes", 64'(obs_d.size()), 64'(tbl[t].exp_dw));
            chk("tbl_error", 64'(error), 64'(tbl[t].exp_err));
            chk("tbl_enable", 64'(cpu_enable), 64'(!tbl[t].exp_err));
            do_abort();
            chk("tbl_abort_error", 64'(error), 64'd0);
            chk("tbl_abort_busy", 64'(busy), 64'd0);
        end

        // Abort after half of word 0, then a clean frame must not reuse the stale bytes.
        obs_i.delete();
        frame = '{8'h01, 8'h00, 8'haa, 8'hbb};
        pulse_start();
        send(4, 0);
        do_abort();
        chk("abort_mid_in_ready", 64'(in_ready), 64'd0);
        chk("abort_mid_busy", 64'(busy), 64'd0);
        chk("abort_mid_no_write", 64'(obs_i.size()), 64'd0);
        frame = '{8'h01, 8'h00, 8'hef, 8'hbe, 8'had, 8'hde, 8'h00, 8'h00};
        run_frame(0);
        chk("abort_then_count", 64'(obs_i.size()), 64'd1);
        if (obs_i.size() == 1) begin
            chk("abort_then_data", obs_i[0].data, 64'hdeadbeef);
            chk("abort_then_addr", obs_i[0].addr, 64'd0);
        end
        do_abort();

        // Reset in the middle of the data-memory phase.
        obs_i.delete();
        obs_d.delete();
        frame = '{8'h01, 8'h00, 8'hde, 8'hc0, 8'had, 8'h0b, 8'h01, 8'h00, 8'h11, 8'h22, 8'h33};
        pulse_start();
        send(11, 0);
        chk("pre_reset_wdata", 64'(wdata_ext), 64'h0badc0de);
        arst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_wdata_ext", 64'(wdata_ext), 64'd0);
        chk("mid_rst_busy", 64'(busy), 64'd0);
        chk("mid_rst_in_ready", 64'(in_ready), 64'd0);
        chk("mid_rst_wen", 64'({wen_ext, wen_ext_2}), 64'd0);
        chk("mid_rst_dmem", addr_ext_2 | wdata_ext_2, 64'd0);
        chk("mid_rst_enable", 64'(cpu_enable), 64'd0);
        chk("mid_rst_no_dmem_write", 64'(obs_d.size()), 64'd0);
        arst_n = 1'b1;
        @(negedge clk);
        build_frame(1, 1);
        run_frame(0);
        do_abort();

        // abort has priority over a simultaneous start.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("abort_wins_busy", 64'(busy), 64'd0);
        chk("abort_wins_in_ready", 64'(in_ready), 64'd0);

        for (int r = 0; r < 12; r++) begin
            int n;
            int m;
            n = (($urandom % 6) == 0) ? 127 + int'($urandom % 4) : int'($urandom % 8);
            m = (($urandom % 6) == 0) ? 127 + int'($urandom % 4) : int'($urandom % 8);
            build_frame(n, m);
            run_frame(int'($urandom % 3));
            do_abort();
            chk("rand_abort_error", 64'(error), 64'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cpu_program_loader.md
Name: cpu_program_loader

Overview:
- Byte-stream boot loader directly upstream of the cpu top. Drives its instruction-memory external port (addr_ext/wen_ext/wdata_ext) and data-memory external port (addr_ext_2/wen_ext_2/wdata_ext_2).
- Deserialises a framed image from a valid/ready byte interface and writes instruction words, then data words.
- Raises the cpu enable only once the whole image is resident.
- Replaces testbench-driven memory preloading for host/UART-fed boot.

Parameters:
- IMEM_WORDS, 128, max instruction words accepted (32-bit).
- DMEM_WORDS, 128, max data words accepted (64-bit).

Ports:
- clk  in  1  main clock
- arst_n  in  1  reset; synchronous, active-low (sampled on clk rising edge despite the name)
- start  in  1  pulse; begins loading from IDLE
- abort  in  1  pulse; returns to IDLE from any state
- in_data  in  8  stream byte
- in_valid  in  1  byte valid
- in_ready  out  1  loader accepts byte (handshake = in_valid & in_ready)
- addr_ext  out  64  imem byte address
- wen_ext  out  1  imem write strobe
- ren_ext  out  1  tied 0
- wdata_ext  out  32  imem write word
- addr_ext_2  out  64  dmem byte address
- wen_ext_2  out  1  dmem write strobe
- ren_ext_2  out  1  tied 0
- wdata_ext_2  out  64  dmem write word
- cpu_enable  out  1  drives cpu enable
- busy  out  1  high in I_CNT..DRAIN
- error  out  1  sticky size-overflow flag

Behaviour:
- Frame format, all fields little-endian:
  - 2-byte N (imem word count), then N×4 bytes.
  - 2-byte M (dmem word count), then M×8 bytes.
- States: IDLE, I_CNT, I_DATA, D_CNT, D_DATA, DRAIN, RUN, ERROR.
- Reset: state IDLE; every output 0; byte/word counters 0; error 0.
- IDLE: in_ready=0; start -> I_CNT.
- I_CNT/D_CNT: in_ready=1; two bytes assemble N/M.
  - After 2nd byte, if N>IMEM_WORDS (M>DMEM_WORDS) -> ERROR.
  - Else if N=0 (M=0) skip: I_CNT->D_CNT, D_CNT->DRAIN.
  - Else -> I_DATA (D_DATA).
- I_DATA: in_ready=1 continuously (no bubbles).
  - On the 4th byte handshake of word i, in the next cycle: wen_ext=1 for exactly one cycle, addr_ext=4*i, wdata_ext=assembled word.
  - After word N-1 -> D_CNT.
- D_DATA: same as I_DATA with 8 bytes per word; addr_ext_2=8*j; wen_ext_2 one-cycle pulse.
  - After word M-1 -> DRAIN.
- Address/data outputs are registered and hold their last value between strobes. wen_ext and wen_ext_2 are never high together.
- DRAIN: in_ready=0; one cycle -> RUN. cpu_enable is high exactly 2 cycles after the final accepted byte of the frame, so the last write strobe completes before the pipeline starts.
- RUN: cpu_enable=1, in_ready=0; start ignored; stays until abort or reset.
- ERROR: error=1, in_ready=0, no write strobes, cpu_enable=0; exit only via abort or reset.
- Bytes offered while in_valid=0 are not consumed; partial-word state holds indefinitely across valid gaps.
- abort in any state: next cycle state IDLE, cpu_enable=0, in_ready=0, counters cleared, pending strobe suppressed, error cleared. abort wins over simultaneous start.
- Reset mid-load: identical to abort; memory contents already written are left as-is.
- Counters: byte index 3 bits; word index 16 bits, compared against the latched N/M. Words do not wrap; overflow is prevented by the size check.

Decomposition:
- Shared package cpu_loader_pkg: state enum, frame field widths (COUNT_BYTES=2, IMEM_BYTES_PER_WORD=4, DMEM_BYTES_PER_WORD=8).
- Sub-module byte_deserializer (parameter WORD_BYTES): assembles little-endian bytes into a word and emits a one-cycle word_valid. Instantiated once, shared by both data phases with WORD_BYTES=8 and a 4-byte early terminate.
- FSM and address counters stay in cpu_program_loader.

Test Plan:
- N=2, words 0x00500093, 0x00a00113; M=1, word 0x1122334455667788; continuous valid.
  -> wen_ext pulses at addr 0 and addr 4 with those words; wen_ext_2 pulses at addr 0 with 0x1122334455667788; cpu_enable rises 2 cycles after the last byte.
- N=0, M=0 (4 zero bytes) -> no write strobes; cpu_enable rises 2 cycles after the 4th byte.
- N=129 (bytes 0x81,0x00) -> error=1, no strobes, cpu_enable stays 0; abort -> IDLE, error=0.
- N=1 with in_valid toggling every other cycle -> a single wen_ext pulse carrying the correct word, 1 cycle after the 4th accepted byte.
- abort asserted after 2 of 4 bytes of word 0, then start and a full frame N=1 word 0xdeadbeef -> one strobe at addr 0 with 0xdeadbeef (no stale bytes mixed in).
- Reset low during D_DATA -> all outputs 0 the next cycle; start is ignored while in RUN.
